// File: rtl/light_stand_pkg.sv
`default_nettype none
// ============================================================================
//  light_stand_pkg
//  --------------------------------------------------------------------------
//  Shared constants and types for the light-stand PWM path: the period
//  counter modulus, the count width, the three lit duty levels and the
//  brightness state encoding.
//
//  Contents:
//    PERIOD     counter modulus (counter sweeps 0..PERIOD-1)
//    CNT_W      width of the period count and every duty value
//    DUTY_*     high-time in counts for each lit brightness level
//    state_e    OFF/LOW/MID/HIGH brightness encoding
//    next_level brightness step taken on a button press (wraps HIGH->OFF)
//
//  Revision: 1.0  initial release
// ============================================================================
package light_stand_pkg;

  localparam int PERIOD = 1000;
  localparam int CNT_W  = 10;

  localparam logic [CNT_W-1:0] DUTY_LOW  = 10'd250;
  localparam logic [CNT_W-1:0] DUTY_MID  = 10'd500;
  // A value >= PERIOD gives a lamp that is constantly on.
  localparam logic [CNT_W-1:0] DUTY_HIGH = 10'd900;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_LOW  = 2'd1,
    ST_MID  = 2'd2,
    ST_HIGH = 2'd3
  } state_e;

  // One press moves one level brighter; HIGH wraps back to OFF.
  function automatic state_e next_level(input state_e cur);
    state_e nxt;
    case (cur)
      ST_OFF:  nxt = ST_LOW;
      ST_LOW:  nxt = ST_MID;
      ST_MID:  nxt = ST_HIGH;
      ST_HIGH: nxt = ST_OFF;
      default: nxt = ST_OFF;
    endcase
    return nxt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_light_driver.sv
`default_nettype none
// ============================================================================
//  pwm_light_driver
//  --------------------------------------------------------------------------
//  Consumer end of the free-running period counter that drives the
//  light-stand lamp. A debounced button steps a four-level brightness
//  state (OFF/LOW/MID/HIGH). The duty for the current level is captured
//  into a shadow register only at period start, so a brightness change
//  never cuts a period short or stretches it. The lamp output is a
//  registered compare of the period count against that duty.
//
//  Ports:
//    i_clk      in   1      system clock
//    i_reset    in   1      asynchronous active-high reset
//    i_counter  in   CNT_W  period count (0..PERIOD-1), same clock domain
//    i_btn      in   1      debounced button level, synchronous to i_clk
//    o_pwm      out  1      registered PWM drive to the lamp
//    o_state    out  2      brightness: 0=OFF 1=LOW 2=MID 3=HIGH
//    o_duty     out  CNT_W  duty currently applied (shadow register)
//
//  Revision: 1.0  initial release
// ============================================================================
module pwm_light_driver #(
  parameter int               CNT_W     = light_stand_pkg::CNT_W,
  parameter logic [CNT_W-1:0] DUTY_LOW  = light_stand_pkg::DUTY_LOW,
  parameter logic [CNT_W-1:0] DUTY_MID  = light_stand_pkg::DUTY_MID,
  parameter logic [CNT_W-1:0] DUTY_HIGH = light_stand_pkg::DUTY_HIGH
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [CNT_W-1:0] i_counter,
  input  logic             i_btn,
  output logic             o_pwm,
  output logic [1:0]       o_state,
  output logic [CNT_W-1:0] o_duty
);

  import light_stand_pkg::*;

  state_e           state;
  logic             btn_d;
  logic             btn_rise;
  logic             period_start;
  logic [CNT_W-1:0] duty_target;
  logic [CNT_W-1:0] duty_shadow;
  logic [CNT_W-1:0] eff_duty;

  // --------------------------------------------------------------------------
  // Button edge detector: one-cycle pulse per press, nothing while held.
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      btn_d <= 1'b0;
    end else begin
      btn_d <= i_btn;
    end
  end

  assign btn_rise = i_btn & ~btn_d;

  // --------------------------------------------------------------------------
  // Brightness FSM.
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= ST_OFF;
    end else if (btn_rise) begin
      state <= next_level(state);
    end
  end

  // --------------------------------------------------------------------------
  // Duty target, decoded from the registered state. Because it is driven
  // from the register, a press landing on the period-start cycle still
  // presents the old level's duty on that cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    duty_target = '0;
    case (state)
      ST_OFF:  duty_target = '0;
      ST_LOW:  duty_target = DUTY_LOW;
      ST_MID:  duty_target = DUTY_MID;
      ST_HIGH: duty_target = DUTY_HIGH;
      default: duty_target = '0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Shadow register: reloads only at period start.
  // --------------------------------------------------------------------------
  assign period_start = (i_counter == '0);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      duty_shadow <= '0;
    end else if (period_start) begin
      duty_shadow <= duty_target;
    end
  end

  // --------------------------------------------------------------------------
  // Comparator. On the period-start cycle the shadow is still holding last
  // period's value, so the freshly selected target is used directly;
  // otherwise a change of level would be one count late at the wrap and a
  // full-on duty would blink low for a cycle.
  // --------------------------------------------------------------------------
  assign eff_duty = period_start ? duty_target : duty_shadow;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_pwm <= 1'b0;
    end else begin
      o_pwm <= (i_counter < eff_duty);
    end
  end

  assign o_state = state;
  assign o_duty  = duty_shadow;

endmodule
`default_nettype wire
